gat_feature_writer: RTL
=======================

// Module: gat_feature_writer
// PURPOSE
//  Parametrised output-feature store for the GAT accelerator. It accepts one packed
//  NUM_FEATURE_OUT-wide feature vector per node from the aggregator over a valid/ready
//  stream and serialises each vector into a dual-port feature BRAM, one element per cycle.
//  The BRAM holds one region per GAT layer. The host reads results back through a
//  byte-addressed port, and a sticky done flag feeds the register bank.
// PARAMETERS
//  DATA_WIDTH      8     width of one feature element
//  NUM_FEATURE_OUT 16    elements per node vector (lanes)
//  NUM_SUBGRAPHS   2708  nodes (vectors) per layer
//  NUM_LAYERS      2     independent layer regions in the BRAM
//  FILL_VALUE      50    element written in test-pattern mode (only with FEAT_TEST_PATTERN_EN)
//  derived: REGION=NUM_SUBGRAPHS*NUM_FEATURE_OUT; DEPTH=REGION*NUM_LAYERS; ADDR_W=$clog2(DEPTH);
//           LANE_W=$clog2(NUM_FEATURE_OUT); NODE_W=$clog2(NUM_SUBGRAPHS); LAYER_W=max(1,$clog2(NUM_LAYERS))
// PORTS
//  clk        in  1                        clock
//  rst_n      in  1                        reset, synchronous, active-low
//  start      in  1                        pulse: clear counters, latch layer_sel, enter RUN
//  layer_sel  in  LAYER_W                  target region (used only when start is high)
//  in_valid   in  1                        feature vector valid
//  in_ready   out 1                        vector accepted when in_valid & in_ready
//  in_data    in  NUM_FEATURE_OUT*DATA_WIDTH  lane 0 = [DATA_WIDTH-1:0]
//  busy       out 1                        state != IDLE/DONE
//  done       out 1                        sticky; all NUM_SUBGRAPHS vectors written
//  ovf_err    out 1                        sticky; in_valid seen while DONE
//  rd_addr    in  ADDR_W+2                 host byte address; element index = rd_addr[ADDR_W+1:2]
//  rd_data    out DATA_WIDTH               read data, 1-cycle latency, always enabled
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=0, busy=0, done=0, ovf_err=0, rd_data=0, counters=0. BRAM contents are not cleared.
//  - FSM: IDLE -start-> RUN. In RUN, the last lane of vector NUM_SUBGRAPHS-1 is written -> DONE. DONE -start-> RUN.
//  - start in any state (including RUN mid-vector): abort the held vector, zero node/lane, clear done/ovf_err,
//    latch layer_sel; RUN from the next cycle. layer_sel >= NUM_LAYERS is clamped to NUM_LAYERS-1.
//  - Serialiser: a holding register plus lane counter. Write address = layer*REGION + node*NUM_FEATURE_OUT + lane.
//    Lane 0 is written in the cycle after acceptance, so each vector takes NUM_FEATURE_OUT write cycles.
//  - in_ready = RUN & (!holding | lane==NUM_FEATURE_OUT-1) & !(final lane of final node). Back-to-back vectors
//    therefore give gap-free writes, and throughput is 1 vector per NUM_FEATURE_OUT cycles.
//  - in_valid low while idle-holding: no write, no counter change. in_ready is 0 in IDLE/DONE.
//  - in_valid high in DONE: ovf_err <= 1, data dropped, done unaffected.
//  - Counter width rule: node and lane counters wrap only through start. An address never exceeds DEPTH-1.
//  - Read/write collision on the same element in the same cycle: rd_data returns the OLD value (read-first).
//  - done rises in the cycle after the final BRAM write. busy and done are never high together.
// CONFIGURATION
//  - `FEAT_TEST_PATTERN_EN defined: adds input port test_mode (1 bit), sampled on start. If it is set, RUN ignores
//    the stream (in_ready=0) and writes FILL_VALUE to every element of the region, one per cycle.
//    done follows after REGION cycles. If test_mode is clear, behaviour is normal.
//  - Not defined: no test_mode port, no fill logic; stream mode only.
// STRUCTURE
//  - gat_pkg: feature-store typedefs (feat_elem_t, lane_idx_t, node_idx_t), the FSM state enum and REGION/DEPTH helpers.
//  - One sub-module, gat_feat_bram: simple dual-port BRAM (write port A, registered read port B), read-first.
//  - Top holds the FSM, serialiser, address generator and sticky flags.
// TESTING (NUM_FEATURE_OUT=4, NUM_SUBGRAPHS=3, NUM_LAYERS=2, DATA_WIDTH=8)
//  1. start, layer 0; 3 back-to-back vectors with bytes 0x01..0x0C -> 12 consecutive write cycles;
//     done 1 cycle after the last write; reading rd_addr=0x2C returns 0x0C.
//  2. start, layer 1; vector {0xA3,0xA2,0xA1,0xA0}, then in_valid low for 5 cycles, then 2 more vectors ->
//     element 12 = 0xA0; layer-0 data intact; no writes during the gap.
//  3. start mid-vector (lane 2) -> lanes 2,3 not written; next vector lands at node 0; done cleared.
//  4. in_valid held after done -> ovf_err=1, in_ready=0, BRAM unchanged; next start clears ovf_err.
//  5. Host reads the address being written that same cycle -> old value; next read returns new value.
//  6. With FEAT_TEST_PATTERN_EN: start with test_mode=1 on layer 1 -> elements 12..23 = 50 after 12 cycles,
//     then done; elements 0..11 untouched.

Source files
------------

// File: rtl/gat_pkg.sv
// Shared types and sizing helpers for the GAT output-feature store.
package gat_pkg;

    localparam int GAT_DATA_WIDTH      = 8;
    localparam int GAT_NUM_FEATURE_OUT = 16;
    localparam int GAT_NUM_SUBGRAPHS   = 2708;

    typedef logic [GAT_DATA_WIDTH-1:0]              feat_elem_t;
    typedef logic [$clog2(GAT_NUM_FEATURE_OUT)-1:0] lane_idx_t;
    typedef logic [$clog2(GAT_NUM_SUBGRAPHS)-1:0]   node_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } feat_state_e;

    function automatic int region_f(input int num_subgraphs, input int num_feature_out);
        return num_subgraphs * num_feature_out;
    endfunction

    function automatic int depth_f(input int region, input int num_layers);
        return region * num_layers;
    endfunction

    // Index width that never collapses to zero for single-entry dimensions.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/gat_feat_bram.sv
// Simple dual-port feature RAM: synchronous write port A, registered read port B.
// A read of the element being written in the same cycle returns the old contents.
module gat_feat_bram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Host addresses past the last element read as zero.
    always_comb begin
        rd_data_d = '0;
        if (32'(rd_addr) < DEPTH) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/gat_feature_writer.sv
// Output-feature store: accepts packed node vectors and serialises them into a per-layer BRAM region.
// Optional FEAT_TEST_PATTERN_EN adds test_mode, which fills the selected region with FILL_VALUE.
//
//  state   | meaning
//  IDLE    | after reset, waiting for start
//  RUN     | accepting vectors (or filling) into the latched layer region
//  DONE    | region complete; further in_valid raises ovf_err
module gat_feature_writer
    import gat_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int NUM_FEATURE_OUT = 16,
    parameter int NUM_SUBGRAPHS   = 2708,
    parameter int NUM_LAYERS      = 2,
    parameter int FILL_VALUE      = 50,
    localparam int REGION  = region_f(NUM_SUBGRAPHS, NUM_FEATURE_OUT),
    localparam int DEPTH   = depth_f(REGION, NUM_LAYERS),
    localparam int ADDR_W  = clog2_min1(DEPTH),
    localparam int LANE_W  = clog2_min1(NUM_FEATURE_OUT),
    localparam int NODE_W  = clog2_min1(NUM_SUBGRAPHS),
    localparam int LAYER_W = clog2_min1(NUM_LAYERS)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
`ifdef FEAT_TEST_PATTERN_EN
    input  logic                                  test_mode,
`endif
    input  logic                                  start,
    input  logic [LAYER_W-1:0]                    layer_sel,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_FEATURE_OUT*DATA_WIDTH-1:0] in_data,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  ovf_err,
    input  logic [ADDR_W+1:0]                     rd_addr,
    output logic [DATA_WIDTH-1:0]                 rd_data
);

    localparam int VEC_W = NUM_FEATURE_OUT * DATA_WIDTH;
    localparam logic [LANE_W-1:0]  LANE_LAST = LANE_W'(NUM_FEATURE_OUT - 1);
    localparam logic [NODE_W-1:0]  NODE_LAST = NODE_W'(NUM_SUBGRAPHS - 1);
    localparam logic [LAYER_W-1:0] LAYER_MAX = LAYER_W'(NUM_LAYERS - 1);

    feat_state_e          state_q, state_d;
    logic [LAYER_W-1:0]   layer_q, layer_d;
    logic [NODE_W-1:0]    node_q, node_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic                 hold_q, hold_d;
    logic [VEC_W-1:0]     vec_q, vec_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, busy_d;

    logic                  fill_mode;
    logic                  lane_last, node_last, accept;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  unused_rd_lsb;

`ifdef FEAT_TEST_PATTERN_EN
    logic tm_q, tm_d;
    assign fill_mode = tm_q;
`else
    assign fill_mode = 1'b0;
`endif

    assign lane_last = (lane_q == LANE_LAST);
    assign node_last = (node_q == NODE_LAST);

    // Ready while the holding register is empty or draining its last lane, except on the region's final lane.
    assign in_ready = (state_q == ST_RUN) && !fill_mode && (!hold_q || lane_last)
                      && !(hold_q && lane_last && node_last);
    // start takes priority over a coincident handshake.
    assign accept   = in_valid && in_ready && !start;

    assign wr_addr = ADDR_W'(layer_q) * ADDR_W'(REGION)
                   + ADDR_W'(node_q) * ADDR_W'(NUM_FEATURE_OUT)
                   + ADDR_W'(lane_q);
    assign wr_data = fill_mode ? DATA_WIDTH'(FILL_VALUE)
                               : vec_q[lane_q*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        node_d  = node_q;
        lane_d  = lane_q;
        hold_d  = hold_q;
        vec_d   = vec_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
`ifdef FEAT_TEST_PATTERN_EN
        tm_d    = tm_q;
`endif
        if (start) begin
            state_d = ST_RUN;
            layer_d = (32'(layer_sel) >= NUM_LAYERS) ? LAYER_MAX : layer_sel;
            node_d  = '0;
            lane_d  = '0;
            hold_d  = 1'b0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
`ifdef FEAT_TEST_PATTERN_EN
            tm_d    = test_mode;
`endif
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (fill_mode || hold_q) begin
                        wr_en = 1'b1;
                        if (lane_last) begin
                            lane_d = '0;
                            if (node_last) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                                hold_d  = 1'b0;
                            end else begin
                                node_d = node_q + 1'b1;
                                hold_d = accept;
                            end
                        end else begin
                            lane_d = lane_q + 1'b1;
                        end
                    end else if (accept) begin
                        hold_d = 1'b1;
                        lane_d = '0;
                    end
                    if (accept) begin
                        vec_d = in_data;
                    end
                end
                ST_DONE: begin
                    if (in_valid) begin
                        ovf_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            layer_q <= '0;
            node_q  <= '0;
            lane_q  <= '0;
            hold_q  <= 1'b0;
            vec_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef FEAT_TEST_PATTERN_EN
            tm_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            node_q  <= node_d;
            lane_q  <= lane_d;
            hold_q  <= hold_d;
            vec_q   <= vec_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
`ifdef FEAT_TEST_PATTERN_EN
            tm_q    <= tm_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf_err = ovf_q;

    // Host addresses are byte-granular; each element occupies one 4-byte word.
    assign unused_rd_lsb = ^rd_addr[1:0];

    gat_feat_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_bram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr[ADDR_W+1:2]),
        .rd_data (rd_data)
    );

endmodule
